// File: rtl/player_move_ctrl.sv
// player_move_ctrl: per-frame movement controller for the maze player sprite.
// On each frame_tick with a button held it picks one direction and computes a
// clamped candidate position. It then probes the two leading sprite corners
// against the wall map over a req/ack handshake, and commits or rejects the move.
// Optional build macro PLAYER_MOVE_RR_ARB_EN: round-robin direction arbitration
// (default build uses fixed priority up > down > left > right).
module player_move_ctrl #(
  parameter int STEP    = 4,
  parameter int SIZE    = 16,
  parameter int X_MIN   = 97,
  parameter int X_MAX   = 720,
  parameter int Y_MIN   = 3,
  parameter int Y_MAX   = 466,
  parameter int X_START = 400,
  parameter int Y_START = 240
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       wall_req,
  output logic [9:0] wall_x,
  output logic [9:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       move_done,
  output logic       move_blocked,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SELECT, PROBE_A, PROBE_B, COMMIT} state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // 11-bit bounds so the clamp compares cannot wrap
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [10:0] X_LO_W    = 11'(X_MIN + STEP);
  localparam logic [10:0] Y_LO_W    = 11'(Y_MIN + STEP);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
  localparam logic [9:0]  EDGE_OFS  = 10'(SIZE - 1);

  state_t      state, state_next;
  logic [3:0]  btn_vec;
  logic [1:0]  grant;
  logic        grant_vld;
  logic [1:0]  dir;
  logic [9:0]  cx, cy;
  logic [9:0]  cand_x, cand_y;
  logic [10:0] x_ext, y_ext;
  logic        at_bound;
  logic [9:0]  corner_x, corner_y;
  logic        lookup_done;

  // Bit index of btn_vec equals the direction code
  assign btn_vec     = {btn_right, btn_left, btn_down, btn_up};
  assign busy        = (state != IDLE);
  assign lookup_done = wall_req && wall_ack;

`ifdef PLAYER_MOVE_RR_ARB_EN
  logic [1:0] last_grant;

  // Round-robin search starting just after the last granted direction
  always_comb begin
    grant     = DIR_UP;
    grant_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!grant_vld && btn_vec[last_grant + 2'(i)]) begin
        grant     = last_grant + 2'(i);
        grant_vld = 1'b1;
      end
    end
  end

  // Pointer moves on every grant, including ones that end blocked
  always_ff @(posedge CLOCK_25) begin
    if (reset)
      last_grant <= DIR_UP;
    else if (state == SELECT && grant_vld)
      last_grant <= grant;
  end
`else
  // Fixed priority up > down > left > right
  always_comb begin
    grant_vld = |btn_vec;
    if (btn_up)        grant = DIR_UP;
    else if (btn_down) grant = DIR_DOWN;
    else if (btn_left) grant = DIR_LEFT;
    else               grant = DIR_RIGHT;
  end
`endif

  // Clamped candidate position for the granted direction
  always_comb begin
    x_ext  = {1'b0, x_pos};
    y_ext  = {1'b0, y_pos};
    cand_x = x_pos;
    cand_y = y_pos;
    case (grant)
      DIR_UP:    cand_y = (y_ext < Y_LO_W) ? 10'(Y_MIN) : 10'(y_ext - STEP_W);
      DIR_DOWN:  cand_y = ((y_ext + STEP_W) > Y_MAX_W) ? 10'(Y_MAX) : 10'(y_ext + STEP_W);
      DIR_LEFT:  cand_x = (x_ext < X_LO_W) ? 10'(X_MIN) : 10'(x_ext - STEP_W);
      default:   cand_x = ((x_ext + STEP_W) > X_MAX_W) ? 10'(X_MAX) : 10'(x_ext + STEP_W);
    endcase
    at_bound = (cand_x == x_pos) && (cand_y == y_pos);
  end

  // Leading-corner probe address for the latched direction
  always_comb begin
    corner_x = cx;
    corner_y = cy;
    case (dir)
      DIR_UP: begin
        if (state == PROBE_B) corner_x = cx + EDGE_OFS;
      end
      DIR_DOWN: begin
        corner_y = cy + EDGE_OFS;
        if (state == PROBE_B) corner_x = cx + EDGE_OFS;
      end
      DIR_LEFT: begin
        if (state == PROBE_B) corner_y = cy + EDGE_OFS;
      end
      default: begin
        corner_x = cx + EDGE_OFS;
        if (state == PROBE_B) corner_y = cy + EDGE_OFS;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLOCK_25) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; ticks seen outside IDLE are dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_tick && (|btn_vec)) state_next = SELECT;
      SELECT:  state_next = (!grant_vld || at_bound) ? IDLE : PROBE_A;
      PROBE_A: if (lookup_done) state_next = wall_hit ? IDLE : PROBE_B;
      PROBE_B: if (lookup_done) state_next = wall_hit ? IDLE : COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched move parameters (no reset needed, only read after SELECT)
  always_ff @(posedge CLOCK_25) begin
    if (state == SELECT) begin
      dir <= grant;
      cx  <= cand_x;
      cy  <= cand_y;
    end
  end

  // Handshake, position and result-pulse registers
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      x_pos        <= 10'(X_START);
      y_pos        <= 10'(Y_START);
      wall_req     <= 1'b0;
      wall_x       <= 10'd0;
      wall_y       <= 10'd0;
      move_done    <= 1'b0;
      move_blocked <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_blocked <= 1'b0;
      case (state)
        SELECT: begin
          if (grant_vld && at_bound) move_blocked <= 1'b1;
        end
        PROBE_A, PROBE_B: begin
          if (!wall_req) begin
            wall_req <= 1'b1;
            wall_x   <= corner_x;
            wall_y   <= corner_y;
          end else if (wall_ack) begin
            wall_req <= 1'b0;
            if (wall_hit) move_blocked <= 1'b1;
          end
        end
        COMMIT: begin
          x_pos     <= cx;
          y_pos     <= cy;
          move_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed bench for player_move_ctrl with a wall-map
// responder that acks in the cycle it first sees wall_req (plus resp_delay).
module tb_player_move_ctrl;

  logic       CLOCK_25 = 1'b0;
  logic       reset, frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       wall_req, wall_ack, wall_hit;
  logic [9:0] wall_x, wall_y, x_pos, y_pos;
  logic       move_done, move_blocked, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // responder controls (written by the test process only)
  logic       resp_en;
  int         resp_delay;
  logic [7:0] hit_seq;
  int         hit_base;
  logic       inject_ack;

  // responder state (written by the responder only)
  int         probe_cnt = 0;
  int         resp_wait = 0;
  logic [9:0] px [64];
  logic [9:0] py [64];

  always #5 CLOCK_25 = ~CLOCK_25;

  player_move_ctrl dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .x_pos(x_pos), .y_pos(y_pos),
    .move_done(move_done), .move_blocked(move_blocked), .busy(busy)
  );

  // Wall-map responder: records each probe and answers from hit_seq
  always @(negedge CLOCK_25) begin
    if (inject_ack) begin
      wall_ack <= 1'b1;
      wall_hit <= 1'b0;
    end else if (resp_en && wall_req && !wall_ack) begin
      if (resp_wait < resp_delay) begin
        resp_wait <= resp_wait + 1;
        wall_ack  <= 1'b0;
        wall_hit  <= 1'b0;
      end else begin
        wall_ack  <= 1'b1;
        wall_hit  <= hit_seq[3'(probe_cnt - hit_base)];
        px[probe_cnt % 64] <= wall_x;
        py[probe_cnt % 64] <= wall_y;
        probe_cnt <= probe_cnt + 1;
        resp_wait <= 0;
      end
    end else begin
      wall_ack <= 1'b0;
      wall_hit <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge CLOCK_25);
    reset = 1'b1; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (2) @(negedge CLOCK_25);
    reset = 1'b0;
  endtask

  // One-cycle frame_tick; returns at the negedge after the tick cycle
  task automatic start_frame();
    @(negedge CLOCK_25);
    frame_tick = 1'b1;
    @(negedge CLOCK_25);
    frame_tick = 1'b0;
  endtask

  task automatic wait_outcome(input int limit, output int cyc, output logic got_done,
                              output logic got_blk);
    cyc = -1; got_done = 1'b0; got_blk = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CLOCK_25);
      if (move_done || move_blocked) begin
        cyc = i; got_done = move_done; got_blk = move_blocked;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic saw;
    apply_reset();
    n_cmp++; if (x_pos !== 10'd400) begin n_bad++; $display("FAIL reset_x: got %0d want 400", x_pos); end
    n_cmp++; if (y_pos !== 10'd240) begin n_bad++; $display("FAIL reset_y: got %0d want 240", y_pos); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (wall_req !== 1'b0 || wall_x !== 10'd0 || wall_y !== 10'd0) begin
      n_bad++; $display("FAIL reset_wall: req=%b x=%0d y=%0d want 0/0/0", wall_req, wall_x, wall_y); end
    n_cmp++; if (move_done !== 1'b0 || move_blocked !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: done=%b blk=%b want 0/0", move_done, move_blocked); end
    start_frame();
    saw = 1'b0;
    repeat (6) begin
      @(negedge CLOCK_25);
      if (wall_req || move_done || move_blocked || busy) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL idle_tick: activity=%b want 0", saw); end
  endtask

  task automatic test_free_move();
    int cyc, base; logic d, b;
    apply_reset();
    base = probe_cnt; hit_base = probe_cnt; hit_seq = 8'h00;
    btn_right = 1'b1;
    start_frame();
    wait_outcome(30, cyc, d, b);
    n_cmp++; if (cyc !== 6 || d !== 1'b1 || b !== 1'b0) begin
      n_bad++; $display("FAIL free_latency: cyc=%0d done=%b blk=%b want 6/1/0", cyc, d, b); end
    n_cmp++; if (x_pos !== 10'd404 || y_pos !== 10'd240) begin
      n_bad++; $display("FAIL free_pos: got (%0d,%0d) want (404,240)", x_pos, y_pos); end
    n_cmp++; if (px[base % 64] !== 10'd419 || py[base % 64] !== 10'd240) begin
      n_bad++; $display("FAIL free_probe_a: got (%0d,%0d) want (419,240)", px[base % 64], py[base % 64]); end
    n_cmp++; if (px[(base+1) % 64] !== 10'd419 || py[(base+1) % 64] !== 10'd255) begin
      n_bad++; $display("FAIL free_probe_b: got (%0d,%0d) want (419,255)", px[(base+1) % 64], py[(base+1) % 64]); end
    @(negedge CLOCK_25);
    n_cmp++; if (move_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL free_pulse_end: done=%b busy=%b want 0/0", move_done, busy); end
    btn_right = 1'b0;
  endtask

  task automatic test_wall_a();
    int cyc, base; logic d, b;
    apply_reset();
    base = probe_cnt; hit_base = probe_cnt; hit_seq = 8'h01;
    btn_up = 1'b1;
    start_frame();
    wait_outcome(30, cyc, d, b);
    n_cmp++; if (cyc !== 3 || b !== 1'b1 || d !== 1'b0) begin
      n_bad++; $display("FAIL wall_a_result: cyc=%0d done=%b blk=%b want 3/0/1", cyc, d, b); end
    n_cmp++; if (px[base % 64] !== 10'd400 || py[base % 64] !== 10'd236) begin
      n_bad++; $display("FAIL wall_a_probe: got (%0d,%0d) want (400,236)", px[base % 64], py[base % 64]); end
    repeat (5) @(negedge CLOCK_25);
    n_cmp++; if (probe_cnt - base !== 1 || wall_req !== 1'b0) begin
      n_bad++; $display("FAIL wall_a_single: probes=%0d req=%b want 1/0", probe_cnt - base, wall_req); end
    n_cmp++; if (y_pos !== 10'd240 || x_pos !== 10'd400) begin
      n_bad++; $display("FAIL wall_a_pos: got (%0d,%0d) want (400,240)", x_pos, y_pos); end
    btn_up = 1'b0;
  endtask

  task automatic test_wall_b();
    int cyc, base; logic d, b;
    apply_reset();
    base = probe_cnt; hit_base = probe_cnt; hit_seq = 8'h02;
    btn_down = 1'b1;
    start_frame();
    wait_outcome(30, cyc, d, b);
    n_cmp++; if (cyc !== 5 || b !== 1'b1 || d !== 1'b0) begin
      n_bad++; $display("FAIL wall_b_result: cyc=%0d done=%b blk=%b want 5/0/1", cyc, d, b); end
    n_cmp++; if (px[base % 64] !== 10'd400 || py[base % 64] !== 10'd259 ||
                 px[(base+1) % 64] !== 10'd415 || py[(base+1) % 64] !== 10'd259) begin
      n_bad++; $display("FAIL wall_b_probes: got (%0d,%0d) (%0d,%0d) want (400,259) (415,259)",
                        px[base % 64], py[base % 64], px[(base+1) % 64], py[(base+1) % 64]); end
    n_cmp++; if (y_pos !== 10'd240) begin n_bad++; $display("FAIL wall_b_pos: got y=%0d want 240", y_pos); end
    btn_down = 1'b0;
  endtask

  task automatic test_boundary();
    int cyc, base, n_ok; logic d, b;
    apply_reset();
    hit_base = probe_cnt; hit_seq = 8'h00;
    btn_left = 1'b1;
    n_ok = 0;
    for (int k = 0; k < 75; k++) begin
      start_frame();
      wait_outcome(30, cyc, d, b);
      if (d === 1'b1) n_ok++;
    end
    n_cmp++; if (n_ok !== 75 || x_pos !== 10'd100) begin
      n_bad++; $display("FAIL bound_walk: moves=%0d x=%0d want 75/100", n_ok, x_pos); end
    base = probe_cnt;
    start_frame();
    wait_outcome(30, cyc, d, b);
    n_cmp++; if (cyc !== 6 || d !== 1'b1 || x_pos !== 10'd97) begin
      n_bad++; $display("FAIL bound_clamp: cyc=%0d done=%b x=%0d want 6/1/97", cyc, d, x_pos); end
    n_cmp++; if (px[base % 64] !== 10'd97 || py[base % 64] !== 10'd240 ||
                 px[(base+1) % 64] !== 10'd97 || py[(base+1) % 64] !== 10'd255) begin
      n_bad++; $display("FAIL bound_probes: got (%0d,%0d) (%0d,%0d) want (97,240) (97,255)",
                        px[base % 64], py[base % 64], px[(base+1) % 64], py[(base+1) % 64]); end
    base = probe_cnt;
    start_frame();
    wait_outcome(30, cyc, d, b);
    n_cmp++; if (cyc !== 1 || b !== 1'b1 || d !== 1'b0) begin
      n_bad++; $display("FAIL bound_block: cyc=%0d done=%b blk=%b want 1/0/1", cyc, d, b); end
    repeat (3) @(negedge CLOCK_25);
    n_cmp++; if (probe_cnt - base !== 0 || x_pos !== 10'd97) begin
      n_bad++; $display("FAIL bound_no_probe: probes=%0d x=%0d want 0/97", probe_cnt - base, x_pos); end
    btn_left = 1'b0;
  endtask

  task automatic test_priority();
    int cyc; logic d, b;
    logic [9:0] ex [3];
    logic [9:0] ey [3];
`ifdef PLAYER_MOVE_RR_ARB_EN
    // pointer starts at up, so the first search begins at down: left, up, left
    ex = '{10'd396, 10'd396, 10'd392};
    ey = '{10'd240, 10'd236, 10'd236};
`else
    ex = '{10'd400, 10'd400, 10'd400};
    ey = '{10'd236, 10'd232, 10'd228};
`endif
    apply_reset();
    hit_base = probe_cnt; hit_seq = 8'h00;
    btn_up = 1'b1; btn_left = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_frame();
      wait_outcome(30, cyc, d, b);
      n_cmp++; if (d !== 1'b1 || x_pos !== ex[k] || y_pos !== ey[k]) begin
        n_bad++; $display("FAIL prio_frame%0d: done=%b pos=(%0d,%0d) want 1 (%0d,%0d)",
                          k, d, x_pos, y_pos, ex[k], ey[k]); end
    end
    btn_up = 1'b0; btn_left = 1'b0;
  endtask

  task automatic test_button_latch();
    int cyc; logic d, b;
    apply_reset();
    hit_base = probe_cnt; hit_seq = 8'h00;
    btn_up = 1'b1;
    start_frame();
    @(negedge CLOCK_25);
    btn_up = 1'b0; btn_down = 1'b1;
    wait_outcome(30, cyc, d, b);
    n_cmp++; if (d !== 1'b1 || y_pos !== 10'd236) begin
      n_bad++; $display("FAIL btn_latch: done=%b y=%0d want 1/236", d, y_pos); end
    btn_down = 1'b0;
  endtask

  task automatic test_overrun();
    int cyc, base; logic d, b;
    apply_reset();
    base = probe_cnt; hit_base = probe_cnt; hit_seq = 8'h00;
    resp_delay = 3;
    btn_right = 1'b1;
    start_frame();
    @(negedge CLOCK_25);
    frame_tick = 1'b1;
    @(negedge CLOCK_25);
    frame_tick = 1'b0;
    wait_outcome(40, cyc, d, b);
    n_cmp++; if (d !== 1'b1 || x_pos !== 10'd404) begin
      n_bad++; $display("FAIL overrun_move: done=%b x=%0d want 1/404", d, x_pos); end
    repeat (12) @(negedge CLOCK_25);
    n_cmp++; if (probe_cnt - base !== 2 || busy !== 1'b0 || x_pos !== 10'd404) begin
      n_bad++; $display("FAIL overrun_single: probes=%0d busy=%b x=%0d want 2/0/404",
                        probe_cnt - base, busy, x_pos); end
    btn_right = 1'b0;
    resp_delay = 0;
  endtask

  task automatic test_reset_abort();
    int waited; logic saw;
    apply_reset();
    resp_en = 1'b0;
    btn_up = 1'b1;
    start_frame();
    waited = 0;
    while (wall_req !== 1'b1 && waited < 10) begin
      @(negedge CLOCK_25);
      waited++;
    end
    n_cmp++; if (wall_req !== 1'b1) begin n_bad++; $display("FAIL abort_req_seen: req=%b want 1", wall_req); end
    reset = 1'b1;
    @(negedge CLOCK_25);
    n_cmp++; if (wall_req !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_clear: req=%b busy=%b want 0/0", wall_req, busy); end
    n_cmp++; if (x_pos !== 10'd400 || y_pos !== 10'd240) begin
      n_bad++; $display("FAIL abort_pos: got (%0d,%0d) want (400,240)", x_pos, y_pos); end
    reset = 1'b0; btn_up = 1'b0;
    @(posedge CLOCK_25); #2 inject_ack = 1'b1;
    @(posedge CLOCK_25); #2 inject_ack = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge CLOCK_25);
      if (wall_req || busy || move_done || move_blocked) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0 || x_pos !== 10'd400 || y_pos !== 10'd240) begin
      n_bad++; $display("FAIL late_ack: activity=%b pos=(%0d,%0d) want 0 (400,240)", saw, x_pos, y_pos); end
    resp_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    resp_en = 1'b1; resp_delay = 0; hit_seq = 8'h00; hit_base = 0; inject_ack = 1'b0;
    test_reset();
    test_free_move();
    test_wall_a();
    test_wall_b();
    test_boundary();
    test_priority();
    test_button_latch();
    test_overrun();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
